// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the p2s_serializer block.
package p2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // Data beats needed to carry one parallel word.
  function automatic int calc_beats(input int data_w, input int lanes);
    return data_w / lanes;
  endfunction

  // Beat counter width; never narrower than one bit.
  function automatic int cnt_width(input int beats);
    return (beats < 2) ? 1 : $clog2(beats);
  endfunction

  // Width of an occupancy counter that must hold 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/p2s_sync_fifo.sv
// Synchronous FIFO with registered read data and a level counter from
// which full/empty are derived.
module p2s_sync_fifo
  import p2s_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             din,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             dout,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  // full/empty are taken before this cycle's read, so a write into a full
  // FIFO is dropped even when a read happens on the same edge.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage array; contents are data only and need no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= din;
  end

  // Registered read port: dout is valid the cycle after rd_en.
  always_ff @(posedge clk) begin
    if (rd_ok) dout <= mem[rptr];
  end

  // Pointers wrap naturally at DEPTH; level moves by +1, -1 or 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter: FIFO-buffered words are shifted out LANES
// bits per beat under a valid/ready handshake, with one LOAD bubble between
// words. Define P2S_PARITY_EN to append an even-parity beat to every word.
module p2s_serializer
  import p2s_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 128,
  parameter int LANES      = 1,
  parameter int AFULL_LVL  = 119,
  parameter int MSB_FIRST  = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DATA_W-1:0]                  par_data,
  input  logic                               par_valid,
  output logic                               par_ready,
  output logic [LANES-1:0]                   ser_data,
  output logic                               ser_valid,
  input  logic                               ser_ready,
  output logic                               ser_last,
  output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
);

  localparam int BEATS = calc_beats(DATA_W, LANES);
`ifdef P2S_PARITY_EN
  localparam int TOTAL = BEATS + 1;
`else
  localparam int TOTAL = BEATS;
`endif
  localparam int CNT_W = cnt_width(TOTAL);
  localparam int LVL_W = level_width(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
  localparam logic [LVL_W-1:0] AFULL_V  = LVL_W'(AFULL_LVL);
`ifdef P2S_PARITY_EN
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BEATS - 1);
`endif

  if (DATA_W % LANES != 0) begin : g_bad_lanes
    $error("p2s_serializer: DATA_W must be a multiple of LANES");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("p2s_serializer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > FIFO_DEPTH) begin : g_bad_afull
    $error("p2s_serializer: AFULL_LVL out of range 1..FIFO_DEPTH");
  end

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr;
  logic              rd;
  logic              last_hs;
`ifdef P2S_PARITY_EN
  logic              par_bit;
`endif

  // Group of bits that goes out first from a word in the shift register.
  function automatic logic [LANES-1:0] head(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return w[DATA_W-1 -: LANES];
    else                return w[LANES-1:0];
  endfunction

  // Shift register contents after one beat has been sent.
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return w << LANES;
    else                return w >> LANES;
  endfunction

`ifdef P2S_PARITY_EN
  // Parity beat: lane 0 carries the even-parity bit, other lanes are zero.
  function automatic logic [LANES-1:0] parity_beat(input logic p);
    logic [LANES-1:0] b;
    b    = '0;
    b[0] = p;
    return b;
  endfunction
`endif

  // Upstream may keep writing past the threshold until the FIFO is truly full.
  assign wr        = par_valid && !fifo_full;
  assign last_hs   = (state == SEND) && ser_valid && ser_ready && (cnt == LAST_IDX);
  assign rd        = ((state == IDLE) || last_hs) && !fifo_empty;
  assign par_ready = (fifo_level < AFULL_V);

  p2s_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr),
    .din     (par_data),
    .rd_en   (rd),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Serializer FSM with registered beat outputs; ser_ready only steers the
  // next-state, never an output directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ser_data  <= '0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
`ifdef P2S_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= LOAD;
        end
        LOAD: begin
          shreg     <= fifo_dout;
          cnt       <= '0;
          ser_data  <= head(fifo_dout);
          ser_valid <= 1'b1;
          ser_last  <= (LAST_IDX == '0);
`ifdef P2S_PARITY_EN
          par_bit   <= ^fifo_dout;
`endif
          state     <= SEND;
        end
        SEND: begin
          if (ser_valid && ser_ready) begin
            if (cnt != LAST_IDX) begin
              cnt      <= cnt + CNT_W'(1);
              shreg    <= advance(shreg);
              ser_last <= ((cnt + CNT_W'(1)) == LAST_IDX);
`ifdef P2S_PARITY_EN
              if (cnt == DATA_LAST) ser_data <= parity_beat(par_bit);
              else                  ser_data <= head(advance(shreg));
`else
              ser_data <= head(advance(shreg));
`endif
            end else begin
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
              state     <= fifo_empty ? IDLE : LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Directed self-checking bench for p2s_serializer: a default-parameter
// instance (1 lane, MSB first) and an 8-bit/4-lane LSB-first instance.
module tb_p2s_serializer;

`ifdef P2S_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int TA = 8 + PAR;
  localparam int TB = 2 + PAR;

  logic       clk;
  logic       reset_n;

  logic [7:0] a_par_data;
  logic       a_par_valid;
  logic       a_par_ready;
  logic [0:0] a_ser_data;
  logic       a_ser_valid;
  logic       a_ser_ready;
  logic       a_ser_last;
  logic [7:0] a_level;

  logic [7:0] b_par_data;
  logic       b_par_valid;
  logic       b_par_ready;
  logic [3:0] b_ser_data;
  logic       b_ser_valid;
  logic       b_ser_ready;
  logic       b_ser_last;
  logic [2:0] b_level;

  int nvec = 0;
  int nerr = 0;

  p2s_serializer u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .par_data   (a_par_data),
    .par_valid  (a_par_valid),
    .par_ready  (a_par_ready),
    .ser_data   (a_ser_data),
    .ser_valid  (a_ser_valid),
    .ser_ready  (a_ser_ready),
    .ser_last   (a_ser_last),
    .fifo_level (a_level)
  );

  p2s_serializer #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .LANES      (4),
    .AFULL_LVL  (3),
    .MSB_FIRST  (0)
  ) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .par_data   (b_par_data),
    .par_valid  (b_par_valid),
    .par_ready  (b_par_ready),
    .ser_data   (b_ser_data),
    .ser_valid  (b_ser_valid),
    .ser_ready  (b_ser_ready),
    .ser_last   (b_ser_last),
    .fifo_level (b_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    nvec++; if (a_ser_data !== 1'b0) begin nerr++; $display("FAIL reset_ser_data got=%b want=0", a_ser_data); end
    nvec++; if (a_ser_valid !== 1'b0) begin nerr++; $display("FAIL reset_ser_valid got=%b want=0", a_ser_valid); end
    nvec++; if (a_ser_last !== 1'b0) begin nerr++; $display("FAIL reset_ser_last got=%b want=0", a_ser_last); end
    nvec++; if (a_level !== 8'd0) begin nerr++; $display("FAIL reset_level got=%0d want=0", a_level); end
    nvec++; if (a_par_ready !== 1'b1) begin nerr++; $display("FAIL reset_par_ready got=%b want=1", a_par_ready); end
    nvec++; if (b_ser_data !== 4'h0 || b_ser_valid !== 1'b0 || b_level !== 3'd0) begin
      nerr++; $display("FAIL reset_b got data=%h valid=%b level=%0d want 0/0/0", b_ser_data, b_ser_valid, b_level);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] bits;
    logic       e;
    bits = 8'hA5;
    a_ser_ready = 1'b1;
    a_par_data  = 8'hA5;
    a_par_valid = 1'b1;
    tick();
    a_par_valid = 1'b0;
    nvec++; if (a_ser_valid !== 1'b0 || a_level !== 8'd1) begin
      nerr++; $display("FAIL single_edge_n got valid=%b level=%0d want valid=0 level=1", a_ser_valid, a_level);
    end
    tick();
    nvec++; if (a_ser_valid !== 1'b0) begin nerr++; $display("FAIL single_edge_n1 got valid=%b want 0", a_ser_valid); end
    tick();
    for (int k = 0; k < TA; k++) begin
      e = (k < 8) ? bits[7-k] : 1'b0;
      nvec++; if (a_ser_valid !== 1'b1 || a_ser_data !== e || a_ser_last !== (k == TA - 1)) begin
        nerr++; $display("FAIL single_beat%0d got v=%b d=%b l=%b want v=1 d=%b l=%b",
                         k, a_ser_valid, a_ser_data, a_ser_last, e, (k == TA - 1));
      end
      tick();
    end
    nvec++; if (a_ser_valid !== 1'b0 || a_level !== 8'd0) begin
      nerr++; $display("FAIL single_idle got valid=%b level=%0d want 0/0", a_ser_valid, a_level);
    end
  endtask

  task automatic test_lanes4();
    logic [3:0] exp_b [3];
    exp_b = '{4'hC, 4'h3, 4'h0};
    b_ser_ready = 1'b1;
    b_par_data  = 8'h3C;
    b_par_valid = 1'b1;
    tick();
    b_par_valid = 1'b0;
    nvec++; if (b_level !== 3'd1 || b_par_ready !== 1'b1) begin
      nerr++; $display("FAIL lanes4_level got level=%0d ready=%b want 1/1", b_level, b_par_ready);
    end
    tick();
    tick();
    for (int k = 0; k < TB; k++) begin
      nvec++; if (b_ser_valid !== 1'b1 || b_ser_data !== exp_b[k] || b_ser_last !== (k == TB - 1)) begin
        nerr++; $display("FAIL lanes4_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, b_ser_valid, b_ser_data, b_ser_last, exp_b[k], (k == TB - 1));
      end
      tick();
    end
    nvec++; if (b_ser_valid !== 1'b0) begin nerr++; $display("FAIL lanes4_idle got valid=%b want 0", b_ser_valid); end
  endtask

  task automatic test_stall();
    logic [23:0] stream;
    logic [2:0]  pbits;
    logic        e;
    logic        held_v, held_d, held_l;
    int          beat, word, pend;
    stream = 24'b00000001_10000000_11111111;
    pbits  = 3'b110;
    beat = 0; word = 0; pend = 0;
    held_v = 1'b0; held_d = 1'b0; held_l = 1'b0;
    a_ser_ready = 1'b0;
    a_par_valid = 1'b1;
    a_par_data = 8'h01; tick();
    a_par_data = 8'h80; tick();
    a_par_data = 8'hFF; tick();
    a_par_valid = 1'b0;
    for (int c = 0; c < 600 && word < 3; c++) begin
      if (held_v) begin
        nvec++; if (a_ser_valid !== 1'b1 || a_ser_data !== held_d || a_ser_last !== held_l) begin
          nerr++; $display("FAIL stall_hold got v=%b d=%b l=%b want v=1 d=%b l=%b",
                           a_ser_valid, a_ser_data, a_ser_last, held_d, held_l);
        end
      end
      if (pend == 1) begin
        nvec++; if (a_ser_valid !== 1'b0) begin nerr++; $display("FAIL stall_bubble got valid=%b want 0", a_ser_valid); end
        pend = 2;
      end else if (pend == 2) begin
        nvec++; if (a_ser_valid !== 1'b1) begin nerr++; $display("FAIL stall_bubble_end got valid=%b want 1", a_ser_valid); end
        pend = 0;
      end
      a_ser_ready = 1'($urandom_range(0, 1));
      if (a_ser_valid && a_ser_ready) begin
        e = (beat < 8) ? stream[23 - word*8 - beat] : pbits[2 - word];
        nvec++; if (a_ser_data !== e || a_ser_last !== (beat == TA - 1)) begin
          nerr++; $display("FAIL stall_w%0d_b%0d got d=%b l=%b want d=%b l=%b",
                           word, beat, a_ser_data, a_ser_last, e, (beat == TA - 1));
        end
        if (beat == TA - 1) begin
          beat = 0;
          word++;
          if (word < 3) pend = 1;
        end else begin
          beat++;
        end
      end
      held_v = a_ser_valid && !a_ser_ready;
      held_d = a_ser_data[0];
      held_l = a_ser_last;
      tick();
    end
    nvec++; if (word != 3) begin nerr++; $display("FAIL stall_timeout got words=%0d want 3", word); end
    a_ser_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    int         got, b;
    a_ser_ready = 1'b0;
    for (int i = 1; i <= 130; i++) begin
      a_par_data  = 8'(i);
      a_par_valid = 1'b1;
      tick();
      if (i == 119) begin
        nvec++; if (a_level !== 8'd118 || a_par_ready !== 1'b1) begin
          nerr++; $display("FAIL bp_119 got level=%0d ready=%b want 118/1", a_level, a_par_ready);
        end
      end
      if (i == 120) begin
        nvec++; if (a_level !== 8'd119 || a_par_ready !== 1'b0) begin
          nerr++; $display("FAIL bp_120 got level=%0d ready=%b want 119/0", a_level, a_par_ready);
        end
      end
      if (i == 129) begin
        nvec++; if (a_level !== 8'd128 || a_par_ready !== 1'b0) begin
          nerr++; $display("FAIL bp_full got level=%0d ready=%b want 128/0", a_level, a_par_ready);
        end
      end
      if (i == 130) begin
        nvec++; if (a_level !== 8'd128) begin nerr++; $display("FAIL bp_drop got level=%0d want 128", a_level); end
      end
    end
    a_par_valid = 1'b0;
    nvec++; if (a_ser_valid !== 1'b1 || a_ser_data !== 1'b0) begin
      nerr++; $display("FAIL bp_first_beat got v=%b d=%b want v=1 d=0", a_ser_valid, a_ser_data);
    end
    a_ser_ready = 1'b1;
    got = 0; b = 0; w = 8'h00;
    for (int c = 0; c < 2000 && got < 129; c++) begin
      if (a_ser_valid) begin
        if (b < 8) w = {w[6:0], a_ser_data};
        b++;
        if (a_ser_last) begin
          nvec++; if (w !== 8'(got + 1)) begin nerr++; $display("FAIL bp_word%0d got=%h want=%h", got + 1, w, 8'(got + 1)); end
          got++;
          b = 0;
        end
      end
      tick();
    end
    nvec++; if (got != 129 || a_ser_valid !== 1'b0 || a_level !== 8'd0) begin
      nerr++; $display("FAIL bp_drain got words=%0d valid=%b level=%0d want 129/0/0", got, a_ser_valid, a_level);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bits;
    logic       e;
    a_ser_ready = 1'b0;
    a_par_valid = 1'b1;
    a_par_data = 8'hF0; tick();
    a_par_data = 8'h11; tick();
    a_par_data = 8'h22; tick();
    a_par_data = 8'h33; tick();
    a_par_data = 8'h44; tick();
    a_par_data = 8'h55; tick();
    a_par_valid = 1'b0;
    nvec++; if (a_level !== 8'd5) begin nerr++; $display("FAIL rmid_queued got level=%0d want 5", a_level); end
    a_ser_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nvec++; if (a_ser_valid !== 1'b1 || a_ser_data !== 1'b1) begin
        nerr++; $display("FAIL rmid_beat%0d got v=%b d=%b want v=1 d=1", k, a_ser_valid, a_ser_data);
      end
      tick();
    end
    reset_n = 1'b0;
    #1;
    nvec++; if (a_ser_valid !== 1'b0 || a_ser_data !== 1'b0 || a_ser_last !== 1'b0) begin
      nerr++; $display("FAIL rmid_outputs got v=%b d=%b l=%b want 0/0/0", a_ser_valid, a_ser_data, a_ser_last);
    end
    nvec++; if (a_level !== 8'd0 || a_par_ready !== 1'b1) begin
      nerr++; $display("FAIL rmid_flush got level=%0d ready=%b want 0/1", a_level, a_par_ready);
    end
    tick();
    reset_n = 1'b1;
    tick();
    bits = 8'h81;
    a_par_data  = 8'h81;
    a_par_valid = 1'b1;
    tick();
    a_par_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < TA; k++) begin
      e = (k < 8) ? bits[7-k] : 1'b0;
      nvec++; if (a_ser_valid !== 1'b1 || a_ser_data !== e || a_ser_last !== (k == TA - 1)) begin
        nerr++; $display("FAIL rmid_next_beat%0d got v=%b d=%b l=%b want v=1 d=%b l=%b",
                         k, a_ser_valid, a_ser_data, a_ser_last, e, (k == TA - 1));
      end
      tick();
    end
    tick();
    nvec++; if (a_ser_valid !== 1'b0 || a_level !== 8'd0) begin
      nerr++; $display("FAIL rmid_idle got valid=%b level=%0d want 0/0", a_ser_valid, a_level);
    end
  endtask

`ifdef P2S_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic [1:0] pexp;
    logic [7:0] bits;
    logic       e;
    words = '{8'h07, 8'h03};
    pexp  = 2'b10;
    a_ser_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      bits = words[n];
      a_par_data  = words[n];
      a_par_valid = 1'b1;
      tick();
      a_par_valid = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 9; k++) begin
        e = (k < 8) ? bits[7-k] : pexp[1-n];
        nvec++; if (a_ser_valid !== 1'b1 || a_ser_data !== e || a_ser_last !== (k == 8)) begin
          nerr++; $display("FAIL parity_w%0d_b%0d got v=%b d=%b l=%b want v=1 d=%b l=%b",
                           n, k, a_ser_valid, a_ser_data, a_ser_last, e, (k == 8));
        end
        tick();
      end
    end
  endtask
`endif

  initial begin
    reset_n     = 1'b0;
    a_par_data  = 8'h00;
    a_par_valid = 1'b0;
    a_ser_ready = 1'b0;
    b_par_data  = 8'h00;
    b_par_valid = 1'b0;
    b_ser_ready = 1'b0;
    test_reset();
    test_single_word();
    test_lanes4();
    test_stall();
    test_backpressure();
    test_reset_mid();
`ifdef P2S_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
